// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-addressed memory port between the instruction
// fetch unit (IF) and the load/store unit (LS).
//
// One transaction is outstanding at a time. LS has priority over IF, but IF
// wins once LS has taken STARVE_LIMIT consecutive grants while IF was waiting.
// Misaligned requests skip the memory and get an error response one cycle
// after acceptance.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   if_req_*          fetch request (valid/ready, byte address)
//   if_rsp_*          fetch response pulse, word data, misalignment error
//   ls_req_*          load/store request (valid/ready, address, we, size, wdata)
//   ls_rsp_*          load/store response pulse, raw word (0 for stores), error
//   mem_*             memory strobe, write enable, word address, byte enables,
//                     lane-replicated write data, read data
//
// Optional build macro ARB_PERF_CNT_EN adds perf_if_grants, perf_ls_grants and
// perf_conflicts (32-bit wrapping counters).
module mem_arbiter #(
   parameter int XLEN         = 32,
   parameter int MEM_LATENCY  = 1,
   parameter int STARVE_LIMIT = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            if_req_valid,
   output logic            if_req_ready,
   input  logic [XLEN-1:0] if_req_addr,
   output logic            if_rsp_valid,
   output logic [XLEN-1:0] if_rsp_data,
   output logic            if_rsp_err,
   input  logic            ls_req_valid,
   output logic            ls_req_ready,
   input  logic [XLEN-1:0] ls_req_addr,
   input  logic            ls_req_we,
   input  logic [1:0]      ls_req_size,
   input  logic [XLEN-1:0] ls_req_wdata,
   output logic            ls_rsp_valid,
   output logic [XLEN-1:0] ls_rsp_data,
   output logic            ls_rsp_err,
   output logic            mem_en,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [3:0]      mem_be,
   output logic [XLEN-1:0] mem_wdata,
   input  logic [XLEN-1:0] mem_rdata
`ifdef ARB_PERF_CNT_EN
   ,
   output logic [31:0]     perf_if_grants,
   output logic [31:0]     perf_ls_grants,
   output logic [31:0]     perf_conflicts
`endif
);

   localparam logic [3:0] LAT_INIT = 4'(MEM_LATENCY - 1);
   localparam logic [3:0] SLIM     = 4'(STARVE_LIMIT);

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

   state_t state, state_nxt;

   logic            if_win, ls_win, accept;
   logic [XLEN-1:0] req_addr;
   logic            req_we;
   logic [3:0]      req_be;
   logic [XLEN-1:0] req_wdata;
   logic            req_mis;

   logic            own_ls;
   logic [XLEN-1:0] addr_q;
   logic            we_q;
   logic [3:0]      be_q;
   logic [XLEN-1:0] wdata_q;
   logic            err_q;
   logic [XLEN-1:0] rdata_q;
   logic [3:0]      lat_cnt;
   logic [3:0]      starve_cnt;

   // Arbitration is only live in IDLE and outside reset, so at most one
   // requester can see ready and no grant is ever given in another state.
   always_comb begin
      if_win = 1'b0;
      ls_win = 1'b0;
      if (state == IDLE && !rst) begin
         if (if_req_valid && (!ls_req_valid || starve_cnt == SLIM))
            if_win = 1'b1;
         else if (ls_req_valid)
            ls_win = 1'b1;
      end
   end

   assign accept = if_win | ls_win;

   // Decode of the winning request: aligned address, byte enables, lane
   // replicated store data and misalignment.
   always_comb begin
      req_addr  = {ls_req_addr[XLEN-1:2], 2'b00};
      req_we    = ls_req_we;
      req_be    = 4'hF;
      req_wdata = '0;
      req_mis   = 1'b0;
      if (if_win) begin
         req_addr = {if_req_addr[XLEN-1:2], 2'b00};
         req_we   = 1'b0;
         req_mis  = |if_req_addr[1:0];
      end else begin
         case (ls_req_size)
            2'd0: begin
               if (ls_req_we) begin
                  req_be    = 4'b0001 << ls_req_addr[1:0];
                  req_wdata = {(XLEN/8){ls_req_wdata[7:0]}};
               end
            end
            2'd1: begin
               req_mis = ls_req_addr[0];
               if (ls_req_we) begin
                  req_be    = 4'b0011 << {ls_req_addr[1], 1'b0};
                  req_wdata = {(XLEN/16){ls_req_wdata[15:0]}};
               end
            end
            2'd2: begin
               req_mis = |ls_req_addr[1:0];
               if (ls_req_we)
                  req_wdata = ls_req_wdata;
            end
            default: req_mis = 1'b1;
         endcase
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = req_mis ? RESP : ACCESS;
         ACCESS:  state_nxt = WAIT;
         WAIT:    if (lat_cnt == '0) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs: everything is driven from registered state so the memory side
   // and the response side are zero outside ACCESS/RESP.
   always_comb begin
      if_req_ready = 1'b0;
      ls_req_ready = 1'b0;
      if_rsp_valid = 1'b0;
      if_rsp_data  = '0;
      if_rsp_err   = 1'b0;
      ls_rsp_valid = 1'b0;
      ls_rsp_data  = '0;
      ls_rsp_err   = 1'b0;
      mem_en       = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = '0;
      mem_be       = '0;
      mem_wdata    = '0;
      case (state)
         IDLE: begin
            if_req_ready = if_win;
            ls_req_ready = ls_win;
         end
         ACCESS: begin
            mem_en    = 1'b1;
            mem_we    = we_q;
            mem_addr  = addr_q;
            mem_be    = be_q;
            mem_wdata = wdata_q;
         end
         RESP: begin
            if (own_ls) begin
               ls_rsp_valid = 1'b1;
               ls_rsp_data  = rdata_q;
               ls_rsp_err   = err_q;
            end else begin
               if_rsp_valid = 1'b1;
               if_rsp_data  = rdata_q;
               if_rsp_err   = err_q;
            end
         end
         default: ;
      endcase
   end

   // Transaction datapath. rdata_q is cleared on accept so error responses
   // and store acks return zero data.
   always_ff @(posedge clk) begin
      if (rst) begin
         own_ls  <= 1'b0;
         addr_q  <= '0;
         we_q    <= 1'b0;
         be_q    <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         lat_cnt <= '0;
      end else begin
         if (accept) begin
            own_ls  <= ls_win;
            addr_q  <= req_addr;
            we_q    <= req_we;
            be_q    <= req_be;
            wdata_q <= req_wdata;
            err_q   <= req_mis;
            rdata_q <= '0;
         end
         if (state == ACCESS)
            lat_cnt <= LAT_INIT;
         else if (state == WAIT && lat_cnt != '0)
            lat_cnt <= lat_cnt - 4'd1;
         if (state == WAIT && lat_cnt == '0 && !we_q)
            rdata_q <= mem_rdata;
      end
   end

   // Starvation guard: counts LS grants taken while IF is waiting.
   always_ff @(posedge clk) begin
      if (rst)
         starve_cnt <= '0;
      else if (if_win)
         starve_cnt <= '0;
      else if (ls_win && if_req_valid) begin
         if (starve_cnt != SLIM)
            starve_cnt <= starve_cnt + 4'd1;
      end else if (state == IDLE && !if_req_valid)
         starve_cnt <= '0;
   end

`ifdef ARB_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_if_grants <= '0;
         perf_ls_grants <= '0;
         perf_conflicts <= '0;
      end else begin
         if (if_win)
            perf_if_grants <= perf_if_grants + 32'd1;
         if (ls_win)
            perf_ls_grants <= perf_ls_grants + 32'd1;
         if (state == IDLE && if_req_valid && ls_req_valid)
            perf_conflicts <= perf_conflicts + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter. Instance dut uses MEM_LATENCY=1,
// instance dut3 uses MEM_LATENCY=3. Inputs change 1ns after the rising edge,
// outputs are sampled 2ns after it.
module tb_mem_arbiter;

   localparam int XLEN = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // ---- latency-1 instance ----
   logic            rst;
   logic            if_req_valid, if_req_ready;
   logic [XLEN-1:0] if_req_addr;
   logic            if_rsp_valid, if_rsp_err;
   logic [XLEN-1:0] if_rsp_data;
   logic            ls_req_valid, ls_req_ready, ls_req_we;
   logic [XLEN-1:0] ls_req_addr, ls_req_wdata;
   logic [1:0]      ls_req_size;
   logic            ls_rsp_valid, ls_rsp_err;
   logic [XLEN-1:0] ls_rsp_data;
   logic            mem_en, mem_we;
   logic [XLEN-1:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]      mem_be;
`ifdef ARB_PERF_CNT_EN
   logic [31:0]     perf_if_grants, perf_ls_grants, perf_conflicts;
`endif

   // ---- latency-3 instance ----
   logic            b_rst;
   logic            b_if_req_valid, b_if_req_ready;
   logic [XLEN-1:0] b_if_req_addr;
   logic            b_if_rsp_valid, b_if_rsp_err;
   logic [XLEN-1:0] b_if_rsp_data;
   logic            b_ls_req_valid, b_ls_req_ready, b_ls_req_we;
   logic [XLEN-1:0] b_ls_req_addr, b_ls_req_wdata;
   logic [1:0]      b_ls_req_size;
   logic            b_ls_rsp_valid, b_ls_rsp_err;
   logic [XLEN-1:0] b_ls_rsp_data;
   logic            b_mem_en, b_mem_we;
   logic [XLEN-1:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
   logic [3:0]      b_mem_be;
`ifdef ARB_PERF_CNT_EN
   logic [31:0]     b_perf_if_grants, b_perf_ls_grants, b_perf_conflicts;
`endif

   mem_arbiter #(.XLEN(XLEN), .MEM_LATENCY(1), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst(rst),
      .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
      .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
      .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_addr(ls_req_addr),
      .ls_req_we(ls_req_we), .ls_req_size(ls_req_size), .ls_req_wdata(ls_req_wdata),
      .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data), .ls_rsp_err(ls_rsp_err),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef ARB_PERF_CNT_EN
      , .perf_if_grants(perf_if_grants), .perf_ls_grants(perf_ls_grants),
      .perf_conflicts(perf_conflicts)
`endif
   );

   mem_arbiter #(.XLEN(XLEN), .MEM_LATENCY(3), .STARVE_LIMIT(4)) dut3 (
      .clk(clk), .rst(b_rst),
      .if_req_valid(b_if_req_valid), .if_req_ready(b_if_req_ready), .if_req_addr(b_if_req_addr),
      .if_rsp_valid(b_if_rsp_valid), .if_rsp_data(b_if_rsp_data), .if_rsp_err(b_if_rsp_err),
      .ls_req_valid(b_ls_req_valid), .ls_req_ready(b_ls_req_ready), .ls_req_addr(b_ls_req_addr),
      .ls_req_we(b_ls_req_we), .ls_req_size(b_ls_req_size), .ls_req_wdata(b_ls_req_wdata),
      .ls_rsp_valid(b_ls_rsp_valid), .ls_rsp_data(b_ls_rsp_data), .ls_rsp_err(b_ls_rsp_err),
      .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_be(b_mem_be),
      .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
`ifdef ARB_PERF_CNT_EN
      , .perf_if_grants(b_perf_if_grants), .perf_ls_grants(b_perf_ls_grants),
      .perf_conflicts(b_perf_conflicts)
`endif
   );

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issues one LS request on dut; returns sampled in cycle T+1.
   task automatic ls_issue(input logic [31:0] addr, input logic we,
                           input logic [1:0] size, input logic [31:0] wdata);
      step();
      ls_req_valid = 1'b1;
      ls_req_addr  = addr;
      ls_req_we    = we;
      ls_req_size  = size;
      ls_req_wdata = wdata;
      #1;
      chk("ls_ready", ls_req_ready, 1'b1);
      chk("if_ready_excl", if_req_ready, 1'b0);
      step();
      ls_req_valid = 1'b0;
      #1;
   endtask

   task automatic if_issue(input logic [31:0] addr);
      step();
      if_req_valid = 1'b1;
      if_req_addr  = addr;
      #1;
      chk("if_ready", if_req_ready, 1'b1);
      chk("ls_ready_excl", ls_req_ready, 1'b0);
      step();
      if_req_valid = 1'b0;
      #1;
   endtask

   // From cycle T+1 of an aligned LS access: checks T+2 quiet, T+3 response.
   task automatic ls_rsp_ok(input logic [31:0] data);
      step(); #1;
      chk("ls_t2_quiet", {mem_en, ls_rsp_valid, if_rsp_valid}, '0);
      step(); #1;
      chk("ls_rsp_valid", ls_rsp_valid, 1'b1);
      chk("ls_rsp_data", ls_rsp_data, data);
      chk("ls_rsp_err", ls_rsp_err, 1'b0);
      chk("ls_rsp_if_quiet", if_rsp_valid, 1'b0);
   endtask

   // One dut3 transaction of aligned IF fetch / LS load; checks the winner,
   // the latency-3 response timing and the routing of the response.
   task automatic b_txn(input logic ifv, input logic lsv, input logic exp_if);
      step();
      b_if_req_valid = ifv;
      b_ls_req_valid = lsv;
      #1;
      chk("b_if_ready", b_if_req_ready, exp_if);
      chk("b_ls_ready", b_ls_req_ready, !exp_if);
      step();
      b_if_req_valid = 1'b0;
      b_ls_req_valid = 1'b0;
      repeat (3) step();
      #1;
      chk("b_t4_no_rsp", {b_if_rsp_valid, b_ls_rsp_valid}, '0);
      step(); #1;
      chk("b_rsp_if", b_if_rsp_valid, exp_if);
      chk("b_rsp_ls", b_ls_rsp_valid, !exp_if);
      if (exp_if) chk("b_if_data", b_if_rsp_data, 32'h13572468);
      else        chk("b_ls_data", b_ls_rsp_data, 32'h13572468);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [9:0] exp_if;
      int         g;

      rst = 1'b1;             b_rst = 1'b1;
      if_req_valid = 1'b1;    ls_req_valid = 1'b1;
      if_req_addr = '0;       ls_req_addr = '0;
      ls_req_we = 1'b0;       ls_req_size = 2'd2;
      ls_req_wdata = '0;      mem_rdata = '0;
      b_if_req_valid = 1'b0;  b_ls_req_valid = 1'b0;
      b_if_req_addr = 32'h20; b_ls_req_addr = 32'h40;
      b_ls_req_we = 1'b0;     b_ls_req_size = 2'd2;
      b_ls_req_wdata = '0;    b_mem_rdata = 32'h13572468;

      // Reset: outputs zero even with both requests pending
      repeat (3) step();
      #1;
      chk("rst_ctl", {if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid,
                      if_rsp_err, ls_rsp_err, mem_en, mem_we, mem_be}, '0);
      chk("rst_addr", mem_addr, '0);
      chk("rst_wdata", mem_wdata, '0);
      chk("rst_rdata", if_rsp_data | ls_rsp_data, '0);
      rst = 1'b0;             b_rst = 1'b0;
      if_req_valid = 1'b0;    ls_req_valid = 1'b0;

      // IF fetch 0x10, latency 1
      mem_rdata = 32'h00112233;
      if_issue(32'h10);
      chk("if_mem_en", mem_en, 1'b1);
      chk("if_mem_addr", mem_addr, 32'h10);
      chk("if_mem_be", mem_be, 4'hF);
      chk("if_mem_we", mem_we, 1'b0);
      step(); #1;
      chk("if_t2_quiet", {mem_en, if_rsp_valid}, '0);
      step(); #1;
      chk("if_rsp_valid", if_rsp_valid, 1'b1);
      chk("if_rsp_data", if_rsp_data, 32'h00112233);
      chk("if_rsp_err", if_rsp_err, 1'b0);
      chk("if_rsp_ls_quiet", ls_rsp_valid, 1'b0);

      // LS byte store 0x7 / 0xAB
      mem_rdata = 32'hDEADBEEF;
      ls_issue(32'h7, 1'b1, 2'd0, 32'h000000AB);
      chk("sb_mem_en", mem_en, 1'b1);
      chk("sb_mem_we", mem_we, 1'b1);
      chk("sb_mem_addr", mem_addr, 32'h4);
      chk("sb_mem_be", mem_be, 4'b1000);
      chk("sb_mem_wdata", mem_wdata, 32'hABABABAB);
      ls_rsp_ok(32'h0);

      // LS half store misaligned 0x5: error at T+1, no memory access
      ls_issue(32'h5, 1'b1, 2'd1, 32'h1234);
      chk("sh_mis_mem_en", mem_en, 1'b0);
      chk("sh_mis_valid", ls_rsp_valid, 1'b1);
      chk("sh_mis_err", ls_rsp_err, 1'b1);
      chk("sh_mis_data", ls_rsp_data, 32'h0);
      step(); #1;
      chk("sh_mis_pulse", ls_rsp_valid, 1'b0);

      // IF misaligned fetch 0x2
      if_issue(32'h2);
      chk("if_mis_mem_en", mem_en, 1'b0);
      chk("if_mis_valid", if_rsp_valid, 1'b1);
      chk("if_mis_err", if_rsp_err, 1'b1);
      chk("if_mis_data", if_rsp_data, 32'h0);

      // LS reserved size
      ls_issue(32'h8, 1'b0, 2'd3, 32'h0);
      chk("rsv_mem_en", mem_en, 1'b0);
      chk("rsv_err", {ls_rsp_valid, ls_rsp_err}, 2'b11);

      // LS word load 0x8
      mem_rdata = 32'hCAFEF00D;
      ls_issue(32'h8, 1'b0, 2'd2, 32'h0);
      chk("lw_mem_en", mem_en, 1'b1);
      chk("lw_mem_we", mem_we, 1'b0);
      chk("lw_mem_addr", mem_addr, 32'h8);
      chk("lw_mem_be", mem_be, 4'hF);
      ls_rsp_ok(32'hCAFEF00D);

      // LS half store 0x6: upper half lanes
      ls_issue(32'h6, 1'b1, 2'd1, 32'hFFFF1234);
      chk("sh_mem_addr", mem_addr, 32'h4);
      chk("sh_mem_be", mem_be, 4'b1100);
      chk("sh_mem_wdata", mem_wdata, 32'h12341234);
      ls_rsp_ok(32'h0);

      // LS byte store 0x1
      ls_issue(32'h1, 1'b1, 2'd0, 32'h00000077);
      chk("sb1_mem_be", mem_be, 4'b0010);
      chk("sb1_mem_wdata", mem_wdata, 32'h77777777);
      ls_rsp_ok(32'h0);

      // Starvation guard with both requests held
      exp_if = 10'b10_0001_0000;
      g = 0;
      step();
      if_req_valid = 1'b1; if_req_addr = 32'h20;
      ls_req_valid = 1'b1; ls_req_addr = 32'h30; ls_req_we = 1'b0; ls_req_size = 2'd2;
      #1;
      for (int cyc = 0; cyc < 200 && g < 10; cyc++) begin
         chk("ready_excl", if_req_ready & ls_req_ready, 1'b0);
         if (if_req_ready || ls_req_ready) begin
            chk($sformatf("grant%0d_is_if", g), if_req_ready, exp_if[g]);
            g++;
         end
         step(); #1;
      end
      chk("grant_count", g, 10);
      if_req_valid = 1'b0; ls_req_valid = 1'b0;
      repeat (4) step();

      // Latency 3: grant mix for the perf counters
      b_txn(1'b1, 1'b1, 1'b0);
      b_txn(1'b1, 1'b0, 1'b1);
      b_txn(1'b1, 1'b1, 1'b0);
      b_txn(1'b1, 1'b0, 1'b1);
      b_txn(1'b1, 1'b0, 1'b1);
`ifdef ARB_PERF_CNT_EN
      step(); #1;
      chk("perf_if", b_perf_if_grants, 32'd3);
      chk("perf_ls", b_perf_ls_grants, 32'd2);
      chk("perf_conf", b_perf_conflicts, 32'd2);
`endif

      // Latency 3: reset during WAIT discards the response
      step();
      b_ls_req_valid = 1'b1; b_ls_req_addr = 32'h40;
      #1;
      chk("b_rst_accept", b_ls_req_ready, 1'b1);
      step();
      b_ls_req_valid = 1'b0;
      #1;
      chk("b_rst_access", b_mem_en, 1'b1);
      step();
      b_rst = 1'b1;
      step(); #1;
      chk("b_rst_ctl", {b_if_req_ready, b_ls_req_ready, b_if_rsp_valid, b_ls_rsp_valid,
                        b_if_rsp_err, b_ls_rsp_err, b_mem_en, b_mem_we, b_mem_be}, '0);
      chk("b_rst_addr", b_mem_addr | b_mem_wdata, '0);
      b_rst = 1'b0;
`ifdef ARB_PERF_CNT_EN
      chk("b_rst_perf", b_perf_if_grants | b_perf_ls_grants | b_perf_conflicts, '0);
`endif
      for (int i = 0; i < 6; i++) begin
         step(); #1;
         chk("b_no_rsp_after_rst", {b_if_rsp_valid, b_ls_rsp_valid, b_mem_en}, '0);
      end
      b_ls_req_addr = 32'h44;
      step();
      b_ls_req_valid = 1'b1;
      #1;
      chk("b_post_accept", b_ls_req_ready, 1'b1);
      step();
      b_ls_req_valid = 1'b0;
      #1;
      chk("b_post_mem_en", b_mem_en, 1'b1);
      chk("b_post_mem_addr", b_mem_addr, 32'h44);
      repeat (3) step();
      #1;
      chk("b_post_t4", b_ls_rsp_valid, 1'b0);
      step(); #1;
      chk("b_post_rsp", b_ls_rsp_valid, 1'b1);
      chk("b_post_data", b_ls_rsp_data, 32'h13572468);
      chk("b_post_err", b_ls_rsp_err, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single data/instruction memory port between the instruction-fetch unit (IF) and the load/store unit (LS). It serialises requests with valid/ready handshakes and applies fixed priority with a starvation guard. It generates word-aligned addresses, byte enables and lane-replicated write data, then returns responses to the winning requester. It sits between the core front-end/LSU and the byte-addressed memory.

Parameters:
XLEN, 32, data and address width
MEM_LATENCY, 1, cycles from the mem_en cycle until mem_rdata is valid (legal range 1..8)
STARVE_LIMIT, 4, consecutive LS grants while IF waits before IF is forced to win (legal range 1..15)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
if_req_valid  in  1  fetch request
if_req_ready  out  1  fetch request accepted this cycle when valid&ready
if_req_addr  in  XLEN  fetch byte address
if_rsp_valid  out  1  fetch response, one-cycle pulse
if_rsp_data  out  XLEN  fetched word
if_rsp_err  out  1  misaligned fetch, qualified by if_rsp_valid
ls_req_valid  in  1  load/store request
ls_req_ready  out  1  LS request accepted when valid&ready
ls_req_addr  in  XLEN  LS byte address
ls_req_we  in  1  1=store, 0=load
ls_req_size  in  2  0=byte, 1=half, 2=word, 3=reserved (treated as misaligned)
ls_req_wdata  in  XLEN  store data, right-aligned
ls_rsp_valid  out  1  LS response, one-cycle pulse (load data or store ack)
ls_rsp_data  out  XLEN  raw loaded word; 0 for stores
ls_rsp_err  out  1  misaligned or reserved-size access
mem_en  out  1  memory access strobe
mem_we  out  1  write enable, qualified by mem_en
mem_addr  out  XLEN  word-aligned address (addr[1:0]=0)
mem_be  out  4  byte enables
mem_wdata  out  XLEN  lane-replicated store data
mem_rdata  in  XLEN  memory read data

Behaviour:
- Reset: FSM to IDLE; all outputs 0; starve counter 0. Any in-flight response is discarded and not reported.
- FSM states: IDLE, ACCESS, WAIT, RESP. Only one transaction is outstanding at a time.
- IDLE: ready is a combinational function of valid and the arbitration result. At most one ready is high per cycle, and ready is 0 in every other state.
- Arbitration: LS wins over IF, except IF wins when starve_cnt==STARVE_LIMIT.
- starve_cnt increments on each LS grant while if_req_valid=1. It clears on an IF grant, and in any IDLE cycle with if_req_valid=0. It saturates at STARVE_LIMIT.
- Accept in cycle T: latch requester id, address, we, be and wdata.
  - Aligned request: go to ACCESS.
  - Misaligned request: go to RESP with err=1 and no memory access. Misaligned means half with addr[0]=1, word with addr[1:0]!=0, size=3, or IF with addr[1:0]!=0.
- ACCESS (cycle T+1): mem_en=1 for exactly one cycle; mem_we=latched we; mem_addr={addr[XLEN-1:2],2'b00}. Then go to WAIT.
- WAIT: a latency counter runs MEM_LATENCY cycles. mem_rdata is captured in cycle T+1+MEM_LATENCY, then go to RESP.
- RESP: the owning rsp_valid is 1 for one cycle, then go to IDLE. The other requester's rsp_valid stays 0.
  - Aligned response: rsp_valid at T+MEM_LATENCY+2 (T+3 for latency 1). Stores follow the same timing with ls_rsp_data=0.
  - Misaligned response: rsp_valid at T+1 with err=1 and data=0.
- Byte enables:
  - byte: 4'b0001<<addr[1:0]
  - half: 4'b0011<<{addr[1],1'b0}
  - word: 4'b1111
  - reads: 4'b1111
- Store data lanes: byte replicates wdata[7:0] into all 4 lanes; half replicates wdata[15:0] into both halves; word passes through.
- mem_* outputs are 0 whenever mem_en=0.
- Requests are not accepted in RESP. A new accept is possible the cycle after RESP, giving a throughput of 1 transaction per MEM_LATENCY+3 cycles.
- rst asserted in any state takes effect at the next edge with no response.

Optional Feature:
ARB_PERF_CNT_EN
- Defined: adds three 32-bit wrapping outputs, all reset to 0.
  - perf_if_grants: +1 per IF accept.
  - perf_ls_grants: +1 per LS accept.
  - perf_conflicts: +1 per IDLE cycle with both valids high.
- Undefined: these ports and their logic are absent. Functional behaviour is identical in both cases.

Test Plan:
- MEM_LATENCY=1, IF fetch addr 0x10, mem_rdata=0x00112233 -> mem_en at T+1 with mem_addr=0x10, mem_be=4'hF; if_rsp_valid at T+3 with data 0x00112233 and err=0.
- LS byte store addr 0x7, wdata 0xAB -> mem_be=4'b1000, mem_wdata=0xABABABAB, mem_we=1; ls_rsp_valid at T+3 with data 0.
- LS half store addr 0x5 -> no mem_en; ls_rsp_valid at T+1 with err=1. LS word load addr 0x8 -> mem_be=4'hF, err=0.
- Both valids held high continuously, STARVE_LIMIT=4 -> grant order LS,LS,LS,LS,IF,LS,LS,LS,LS,IF.
- MEM_LATENCY=3, LS load accepted, then rst pulsed in WAIT -> no rsp_valid; all outputs 0 the next cycle; next request completes normally.
- ARB_PERF_CNT_EN defined, 3 IF and 2 LS grants with 2 contention cycles -> perf_if_grants=3, perf_ls_grants=2, perf_conflicts=2.
